// File: rtl/wb_dcache_mem_adapter_pkg.sv
// Shared definitions for the write-back data cache memory adapter.
// Holds the adapter state encoding and the line/beat sizing helpers.
package wb_dcache_mem_adapter_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int DCACHE_BUS_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } type_dcache_mem_states_e;

  function automatic int line_words(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // A single-word line still needs a 1-bit beat counter.
  function automatic int beat_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int DCACHE_LINE_WORDS = line_words(DCACHE_LINE_WIDTH, DCACHE_BUS_WIDTH);
  localparam int DCACHE_BEAT_W     = beat_width(DCACHE_LINE_WORDS);

endpackage

// File: rtl/dcache_line_buffer.sv
// Line buffer for the cache memory adapter: selects the outgoing write word
// for a beat and assembles incoming read beats into a full line.
module dcache_line_buffer #(
  parameter int LINE_WIDTH = 128,
  parameter int BUS_WIDTH  = 32,
  parameter int BEAT_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  store,
  input  logic [BEAT_W-1:0]     store_idx,
  input  logic [BUS_WIDTH-1:0]  store_data,
  input  logic [LINE_WIDTH-1:0] wline,
  input  logic [BEAT_W-1:0]     wsel,
  output logic [BUS_WIDTH-1:0]  wword,
  output logic [LINE_WIDTH-1:0] line_merged
);

  localparam int WORDS = LINE_WIDTH / BUS_WIDTH;

  logic [WORDS-1:0][BUS_WIDTH-1:0] slots;
  logic [WORDS-1:0][BUS_WIDTH-1:0] wwords;
  logic [WORDS-1:0][BUS_WIDTH-1:0] merged;

  assign wwords      = wline;
  assign wword       = wwords[wsel];
  assign line_merged = merged;

  // Merged view lets the final beat land in the returned line the same cycle it is acked.
  always_comb begin
    merged = slots;
    if (store) merged[store_idx] = store_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else if (clear) begin
      slots <= '0;
    end else if (store) begin
      slots <= merged;
    end
  end

endmodule

// File: rtl/wb_dcache_mem_adapter.sv
// Converts a cache line request into sequential word beats on the data bus.
// Optional per-beat watchdog enabled with `define DCACHE_BUS_TIMEOUT_EN.
module wb_dcache_mem_adapter
  import wb_dcache_mem_adapter_pkg::*;
#(
  parameter int LINE_WIDTH     = DCACHE_LINE_WIDTH,
  parameter int BUS_WIDTH      = DCACHE_BUS_WIDTH,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dcache2mem_req_i,
  input  logic                  dcache2mem_wr_i,
  input  logic [ADDR_WIDTH-1:0] dcache2mem_addr_i,
  input  logic [LINE_WIDTH-1:0] dcache2mem_wdata_i,
  input  logic                  dcache_kill_i,
  output logic                  mem2dcache_ack_o,
  output logic [LINE_WIDTH-1:0] mem2dcache_rdata_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [BUS_WIDTH-1:0]  bus_wdata_o,
  input  logic                  bus_ack_i,
  input  logic [BUS_WIDTH-1:0]  bus_rdata_i,
  output logic                  timeout_err_o
);

  localparam int LINE_WORDS = line_words(LINE_WIDTH, BUS_WIDTH);
  localparam int BEAT_W     = beat_width(LINE_WORDS);
  localparam int LINE_OFF   = $clog2(LINE_WIDTH / 8);
  localparam int BYTE_SH    = $clog2(BUS_WIDTH / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_BEAT  = BEAT;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]            state;
  logic [BEAT_W-1:0]     beat;
  logic [BEAT_W-1:0]     next_beat;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] req_base;
  logic                  wr;
  logic [LINE_WIDTH-1:0] wdata;
  logic [LINE_WIDTH-1:0] wline;
  logic [BEAT_W-1:0]     wsel;
  logic [BUS_WIDTH-1:0]  wword;
  logic [LINE_WIDTH-1:0] line_merged;
  logic                  accept;
  logic                  store;
  logic                  abort;
  logic                  timeout;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^dcache2mem_addr_i[LINE_OFF-1:0];
  assign req_base  = {dcache2mem_addr_i[ADDR_WIDTH-1:LINE_OFF], {LINE_OFF{1'b0}}};
  assign next_beat = beat + BEAT_W'(1);
  assign accept    = (state == S_IDLE) && dcache2mem_req_i && !dcache_kill_i;
  assign store     = (state == S_BEAT) && bus_ack_i && !wr;
  assign abort     = dcache_kill_i || !dcache2mem_req_i;

  // Reads carry zero write data, so the line is only latched for write-backs.
  assign wline = (state == S_IDLE) ? (dcache2mem_wr_i ? dcache2mem_wdata_i : '0) : wdata;
  assign wsel  = (state == S_IDLE) ? '0 : next_beat;

  dcache_line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH),
    .BEAT_W     (BEAT_W)
  ) u_line_buffer (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .clear       (accept),
    .store       (store),
    .store_idx   (beat),
    .store_data  (bus_rdata_i),
    .wline       (wline),
    .wsel        (wsel),
    .wword       (wword),
    .line_merged (line_merged)
  );

`ifdef DCACHE_BUS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd;

  assign timeout = ((state == S_BEAT) || (state == S_DRAIN)) && !bus_ack_i &&
                   (wd == WD_W'(TIMEOUT_CYCLES - 1));

  // Restarts on every ack so each newly presented beat gets the full budget.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd            <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      timeout_err_o <= timeout;
      if (((state == S_BEAT) || (state == S_DRAIN)) && !bus_ack_i && !timeout) wd <= wd + WD_W'(1);
      else wd <= '0;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout       = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state              <= S_IDLE;
      beat               <= '0;
      base               <= '0;
      wr                 <= 1'b0;
      wdata              <= '0;
      mem2dcache_ack_o   <= 1'b0;
      mem2dcache_rdata_o <= '0;
      bus_req_o          <= 1'b0;
      bus_we_o           <= 1'b0;
      bus_addr_o         <= '0;
      bus_wdata_o        <= '0;
    end else begin
      mem2dcache_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            base        <= req_base;
            wr          <= dcache2mem_wr_i;
            wdata       <= wline;
            beat        <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= dcache2mem_wr_i;
            bus_addr_o  <= req_base;
            bus_wdata_o <= wword;
            state       <= S_BEAT;
          end
        end
        S_BEAT: begin
          if (bus_ack_i && (abort || beat == LAST_BEAT)) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if (abort) begin
              state <= S_IDLE;
            end else begin
              state            <= S_DONE;
              mem2dcache_ack_o <= 1'b1;
              if (!wr) mem2dcache_rdata_o <= line_merged;
            end
          end else if (bus_ack_i) begin
            beat        <= next_beat;
            bus_addr_o  <= base + (ADDR_WIDTH'(next_beat) << BYTE_SH);
            bus_wdata_o <= wword;
          end else if (timeout) begin
            // Unacked words stay zero since the buffer was cleared at accept.
            bus_req_o        <= 1'b0;
            bus_we_o         <= 1'b0;
            bus_addr_o       <= '0;
            bus_wdata_o      <= '0;
            state            <= S_DONE;
            mem2dcache_ack_o <= 1'b1;
            if (!wr) mem2dcache_rdata_o <= line_merged;
          end else if (abort) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus_ack_i || timeout) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            state       <= S_IDLE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_dcache_mem_adapter.md
Name: wb_dcache_mem_adapter

Overview:
- Sits directly downstream of the write-back data cache controller/datapath and upstream of the word-wide data memory bus.
- Converts one cache-line request (write-back or allocate) into LINE_WORDS sequential word beats on the memory bus.
- Assembles read beats into a full line and returns a single-cycle line acknowledge to the cache.
- Honours request kill from the cache side without violating the bus handshake.

Parameters:
- LINE_WIDTH, 128, cache line width in bits; must equal the cache datapath line width.
- BUS_WIDTH, 32, memory bus data width; LINE_WIDTH must be an integer multiple of it.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, per-beat watchdog limit; used only with DCACHE_BUS_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- dcache2mem_req_i  in  1  line request from the cache, held high until mem2dcache_ack_o.
- dcache2mem_wr_i  in  1  1 = write-back, 0 = allocate (read).
- dcache2mem_addr_i  in  ADDR_WIDTH  line address; low log2(LINE_WIDTH/8) bits are ignored.
- dcache2mem_wdata_i  in  LINE_WIDTH  write-back line data.
- dcache_kill_i  in  1  abort the current line transfer (driven when data memory is not selected).
- mem2dcache_ack_o  out  1  one-cycle line-done pulse.
- mem2dcache_rdata_o  out  LINE_WIDTH  assembled read line.
- bus_req_o  out  1  beat request.
- bus_we_o  out  1  beat write enable.
- bus_addr_o  out  ADDR_WIDTH  beat byte address.
- bus_wdata_o  out  BUS_WIDTH  beat write data.
- bus_ack_i  in  1  beat acknowledge, single-cycle pulse.
- bus_rdata_i  in  BUS_WIDTH  beat read data, valid with bus_ack_i.
- timeout_err_o  out  1  watchdog error pulse.

Behaviour:
- LINE_WORDS = LINE_WIDTH/BUS_WIDTH. The beat counter is log2(LINE_WORDS) bits wide, with a minimum of 1 bit.
- All outputs are registered.
- Reset (asynchronous) drives every output to 0, clears the line buffer, the beat counter and the watchdog, and sets state to IDLE. Reset asserted mid-burst abandons the burst immediately.
- States: IDLE, BEAT, DRAIN, DONE.
- IDLE:
  - If dcache2mem_req_i=1 and dcache_kill_i=0: latch the line-aligned address, wr, and wdata (writes only); set beat=0; go to BEAT.
  - Otherwise stay in IDLE.
- BEAT:
  - Drive bus_req_o=1, bus_we_o=wr, bus_addr_o=base+beat*(BUS_WIDTH/8), bus_wdata_o=wdata slice [beat], word 0 = LSBs.
  - Address, data and we are stable while bus_req_o=1 and no ack has arrived.
  - On bus_ack_i:
    - Read: store bus_rdata_i into line buffer slot [beat].
    - If beat==LINE_WORDS-1, go to DONE.
    - Otherwise beat+1; the next beat's address/data appear the following cycle, and bus_req_o stays high throughout.
  - Kill or req drop seen in BEAT without ack: go to DRAIN. The bus request cannot be retracted.
  - Kill coincident with ack: the ack completes the beat, then go to IDLE with no upstream ack.
- DRAIN:
  - Hold the current beat until bus_ack_i, discard any data, then go to IDLE.
  - No mem2dcache_ack_o is issued.
- DONE:
  - mem2dcache_ack_o=1 for exactly one cycle; bus_req_o=0.
  - mem2dcache_rdata_o is valid this cycle and holds until the next read completes.
  - Go to IDLE, even if kill is asserted this cycle.
- Latency: with a slave acking one cycle after each beat is presented, the ack arrives in cycle 2*LINE_WORDS+1, counting the upstream-request sample cycle as 0.
- Stray bus_ack_i in IDLE or DONE is ignored.

Optional Feature:
- Macro: DCACHE_BUS_TIMEOUT_EN.
- Enabled:
  - A per-beat counter resets whenever a new beat is presented.
  - On reaching TIMEOUT_CYCLES with no ack: bus_req_o drops, timeout_err_o pulses for 1 cycle, and the block goes to DONE. Read data for the remaining words is zero.
- Disabled:
  - The counter is absent and timeout_err_o is tied to 0.
  - The block waits indefinitely.

Decomposition:
- Shared cache package holds:
  - the type_dcache_mem_states_e enum (IDLE/BEAT/DRAIN/DONE);
  - the LINE_WORDS and beat-offset width constants;
  - DCACHE line width default.
- One sub-module is natural: dcache_line_buffer. It performs write-slice select and read-beat assembly, indexed by beat.

Test Plan:
- Allocate at addr 0x8000_0010 (aligned to 0x8000_0010), slave returns 0x11,0x22,0x33,0x44 with 1-cycle ack -> addresses 0x..10/14/18/1C, ack in cycle 9, rdata=0x00000044_00000033_00000022_00000011.
- Write-back addr 0x100, wdata 0xDDDD_CCCC_BBBB_AAAA_… -> four beats with bus_we_o=1 at 0x100..0x10C carrying words LSB-first, single ack pulse, rdata unchanged.
- Slave wait of 5 cycles on beat 2 -> addr/wdata held stable for 5 cycles, total ack delayed by 4 cycles.
- Kill asserted while beat 1 is pending -> bus_req_o held until that ack, then IDLE; no mem2dcache_ack_o; next request starts at beat 0.
- Reset asserted mid-beat 2 -> all outputs 0 asynchronously; after release, a new allocate completes normally.
- With DCACHE_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks beat 0 -> timeout_err_o and mem2dcache_ack_o pulse after 8 cycles, rdata=0.
